mcpu_core: RTL and testbench
============================

Name: mcpu_core

Overview:
- Small multicycle 16-bit CPU with its own program/data RAM and register file; top of the CPU subsystem.
- A bench preloads the RAM and registers through hierarchy, releases reset, and the core fetches and executes from address 0.
- Memory-internal names are fixed for bench access: RAM instance `raminst` with array `mem`; register file instance `regfileinst` with array `R[0..15]`.

Parameters:
- WORD_SIZE, 16, datapath, register and RAM word width.
- INSTRUCTION_SIZE, 16, instruction width.
- OPCODE_SIZE, 4, opcode field width.
- OPERAND_SIZE, 4, register-index field width.
- RAM_SIZE, 256, RAM depth in words; also exposed as a parameter of `raminst`.
- OP_NOP=0, OP_ADD=1, OP_SUB=2, OP_AND=3, OP_OR=4, OP_XOR=5, OP_NOT=6, OP_LSL=7, OP_LSR=8, OP_SHORT_TO_REG=9, OP_LOAD=10, OP_STORE=11, OP_JMP=12, OP_BEQZ=13, OP_MOV=14, OP_HALT=15: opcode constants, all visible as top-level parameters.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.

Behaviour:
- Instruction format: [15:12] opcode, [11:8] ra, [7:4] rb, [3:0] rc.
- Imm-form instructions use imm8 = [7:0].
- Register ops, all arithmetic mod 2^16:
  - ADD: R[ra] = R[rb] + R[rc].
  - SUB: R[ra] = R[rb] - R[rc].
  - AND, OR, XOR: bitwise on R[rb], R[rc].
  - NOT: R[ra] = ~R[rb].
  - MOV: R[ra] = R[rb].
- Shifts:
  - LSL: R[ra] = R[rb] << R[rc]. LSR: logical right shift.
  - Shift amount is the full 16-bit R[rc]; any amount >= 16 yields 0.
- SHORT_TO_REG: R[ra] = {8'h00, imm8}, zero-extended.
- Memory ops: LOAD: R[ra] = mem[R[rb][7:0]]. STORE: mem[R[rb][7:0]] = R[ra].
- Jumps:
  - JMP: PC = imm8.
  - BEQZ: if R[ra] == 0 then PC = imm8, else fall through.
- NOP: no architectural change.
- HALT: see Optional Feature.
- Register-index fields may alias, e.g. LSL R0,R0,R3. Sources are read before the write, so the old value is used.
- PC is 8 bits and wraps 255 -> 0. After a program, zero words execute as NOP.
- FSM states:
  - FETCH: IR <= mem[PC]; PC <= PC+1; go to EXEC.
  - EXEC:
    - ALU, MOV, SHORT_TO_REG: write R[ra]; go to FETCH.
    - JMP, BEQZ: update PC; go to FETCH.
    - LOAD, STORE: go to MEM.
  - MEM: perform the RAM read-and-writeback or the RAM write; go to FETCH.
  - HALTED: no change.
- Latency: 2 cycles per instruction; LOAD and STORE take 3.
- RAM is synchronous-write. Reads are combinational from `mem` so FETCH completes in one cycle.
- Reset (reset=0, asynchronous): PC=0, IR=0, state=FETCH.
  - RAM and register file are not cleared, so bench preload survives.
  - Reset asserted mid-instruction aborts it; no partial register or RAM write occurs after reset assertion.
  - On release, the first rising edge performs FETCH of mem[0].
- No register is hardwired to zero.

Optional Feature:
- Macro MCPU_HALT_EN.
- Defined: OP_HALT enters state HALTED. PC, registers and RAM freeze until reset.
- Undefined: opcode 15 behaves as NOP.

Test Plan:
- mem[0..4] = {SHORT_TO_REG R0 0x13; SHORT_TO_REG R1 0xEE; SHORT_TO_REG R3 8; LSL R0,R0,R3; ADD R2,R1,R0}, reset pulse -> after 10 cycles R0=0x1300, R1=0x00EE, R2=0x13EE (5102).
- Continue mem[5..9] = {SHORT_TO_REG R4 0x13; SHORT_TO_REG R5 0xFC; SHORT_TO_REG R6 8; LSL R4,R4,R6; ADD R7,R4,R5} -> R4=0x1300, R7=0x13FC (5116); R2 unchanged.
- R1=0x8001, R2=16, LSL R3,R1,R2 -> R3=0; R2=1, LSR R4,R1,R2 -> R4=0x4000; SUB 0-1 -> 0xFFFF.
- STORE R5 to address R6=0x80, then LOAD R7 from R6 -> mem[0x80]=R5, R7=R5; the LOAD takes 3 cycles.
- BEQZ on R8=0 to 0x20 -> PC=0x20 and the instruction at 0x20 executes. JMP 0x05 loop -> PC revisits 5.
- Assert reset low during EXEC of an ADD -> PC=0 immediately and the target register is unchanged. With MCPU_HALT_EN defined, HALT -> PC is stable for 20 cycles.

Source files
------------

// File: rtl/mcpu_core_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mcpu_core_if : single-port RAM bus between the mcpu core and its RAM     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface mcpu_core_if #(
    parameter int AW = 8,
    parameter int DW = 16
);
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          we;

    modport master (output addr, output wdata, output we, input rdata);
    modport slave  (input addr, input wdata, input we, output rdata);
endinterface
`default_nettype wire

// File: rtl/mcpu_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mcpu_core : multicycle 16-bit CPU with local RAM and 16-entry regfile    |
// | Optional macro MCPU_HALT_EN: opcode 15 freezes the core until reset.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+

module mcpu_ram #(
    parameter int WORD_SIZE = 16,
    parameter int RAM_SIZE  = 256
) (
    input wire logic   clk,
    mcpu_core_if.slave bus
);
    logic [WORD_SIZE-1:0] mem [0:RAM_SIZE-1];

    always_ff @(posedge clk) begin
        if (bus.we) mem[bus.addr] <= bus.wdata;
    end

    // Combinational read lets FETCH complete in a single cycle.
    assign bus.rdata = mem[bus.addr];
endmodule

module mcpu_regfile #(
    parameter int WORD_SIZE    = 16,
    parameter int OPERAND_SIZE = 4
) (
    input  wire logic                    clk,
    input  wire logic                    i_we,
    input  wire logic [OPERAND_SIZE-1:0] i_ra,
    input  wire logic [OPERAND_SIZE-1:0] i_rb,
    input  wire logic [OPERAND_SIZE-1:0] i_rc,
    input  wire logic [WORD_SIZE-1:0]    i_wdata,
    output logic      [WORD_SIZE-1:0]    o_ra,
    output logic      [WORD_SIZE-1:0]    o_rb,
    output logic      [WORD_SIZE-1:0]    o_rc
);
    logic [WORD_SIZE-1:0] R [0:(2**OPERAND_SIZE)-1];

    always_ff @(posedge clk) begin
        if (i_we) R[i_ra] <= i_wdata;
    end

    assign o_ra = R[i_ra];
    assign o_rb = R[i_rb];
    assign o_rc = R[i_rc];
endmodule

module mcpu_core #(
    parameter int WORD_SIZE        = 16,
    parameter int INSTRUCTION_SIZE = 16,
    parameter int OPCODE_SIZE      = 4,
    parameter int OPERAND_SIZE     = 4,
    parameter int RAM_SIZE         = 256,
    parameter logic [OPCODE_SIZE-1:0] OP_NOP          = 4'd0,
    parameter logic [OPCODE_SIZE-1:0] OP_ADD          = 4'd1,
    parameter logic [OPCODE_SIZE-1:0] OP_SUB          = 4'd2,
    parameter logic [OPCODE_SIZE-1:0] OP_AND          = 4'd3,
    parameter logic [OPCODE_SIZE-1:0] OP_OR           = 4'd4,
    parameter logic [OPCODE_SIZE-1:0] OP_XOR          = 4'd5,
    parameter logic [OPCODE_SIZE-1:0] OP_NOT          = 4'd6,
    parameter logic [OPCODE_SIZE-1:0] OP_LSL          = 4'd7,
    parameter logic [OPCODE_SIZE-1:0] OP_LSR          = 4'd8,
    parameter logic [OPCODE_SIZE-1:0] OP_SHORT_TO_REG = 4'd9,
    parameter logic [OPCODE_SIZE-1:0] OP_LOAD         = 4'd10,
    parameter logic [OPCODE_SIZE-1:0] OP_STORE        = 4'd11,
    parameter logic [OPCODE_SIZE-1:0] OP_JMP          = 4'd12,
    parameter logic [OPCODE_SIZE-1:0] OP_BEQZ         = 4'd13,
    parameter logic [OPCODE_SIZE-1:0] OP_MOV          = 4'd14,
    parameter logic [OPCODE_SIZE-1:0] OP_HALT         = 4'd15
) (
    input wire logic clk,
    input wire logic reset
);
    localparam int c_PC_W = 8;
    localparam int c_SH_W = $clog2(WORD_SIZE);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_EXEC   = 2'd1,
        S_MEM    = 2'd2,
        S_HALTED = 2'd3
    } state_t;

`ifdef MCPU_HALT_EN
    localparam state_t c_HALT_STATE = S_HALTED;
`else
    localparam state_t c_HALT_STATE = S_FETCH;
`endif

    state_t                      r_state, w_state_nxt;
    logic [c_PC_W-1:0]           r_pc, w_pc_nxt;
    logic [INSTRUCTION_SIZE-1:0] r_ir, w_ir_nxt;

    logic [OPCODE_SIZE-1:0]  w_opcode;
    logic [OPERAND_SIZE-1:0] w_ra_idx, w_rb_idx, w_rc_idx;
    logic [7:0]              w_imm8;
    logic [WORD_SIZE-1:0]    w_ra_val, w_rb_val, w_rc_val, w_alu;
    logic                    w_rf_we;
    logic [WORD_SIZE-1:0]    w_rf_wdata;
    logic                    w_ram_we;
    logic [c_PC_W-1:0]       w_ram_addr;
    logic [WORD_SIZE-1:0]    w_ram_wdata, w_ram_rdata;

    assign w_opcode = r_ir[INSTRUCTION_SIZE-1 -: OPCODE_SIZE];
    assign w_ra_idx = r_ir[3*OPERAND_SIZE-1 -: OPERAND_SIZE];
    assign w_rb_idx = r_ir[2*OPERAND_SIZE-1 -: OPERAND_SIZE];
    assign w_rc_idx = r_ir[OPERAND_SIZE-1:0];
    assign w_imm8   = r_ir[7:0];

    mcpu_core_if #(.AW(c_PC_W), .DW(WORD_SIZE)) u_ram_bus ();

    // RAM port is shared: data access in MEM, instruction fetch otherwise.
    assign w_ram_addr  = (r_state == S_MEM) ? w_rb_val[c_PC_W-1:0] : r_pc;
    assign w_ram_we    = (r_state == S_MEM) && (w_opcode == OP_STORE);
    assign w_ram_wdata = w_ra_val;

    assign u_ram_bus.addr  = w_ram_addr;
    assign u_ram_bus.wdata = w_ram_wdata;
    assign u_ram_bus.we    = w_ram_we;
    assign w_ram_rdata     = u_ram_bus.rdata;

    mcpu_ram #(
        .WORD_SIZE (WORD_SIZE),
        .RAM_SIZE  (RAM_SIZE)
    ) raminst (
        .clk (clk),
        .bus (u_ram_bus.slave)
    );

    mcpu_regfile #(
        .WORD_SIZE    (WORD_SIZE),
        .OPERAND_SIZE (OPERAND_SIZE)
    ) regfileinst (
        .clk     (clk),
        .i_we    (w_rf_we),
        .i_ra    (w_ra_idx),
        .i_rb    (w_rb_idx),
        .i_rc    (w_rc_idx),
        .i_wdata (w_rf_wdata),
        .o_ra    (w_ra_val),
        .o_rb    (w_rb_val),
        .o_rc    (w_rc_val)
    );

    always_comb begin
        w_alu = '0;
        case (w_opcode)
            OP_ADD:          w_alu = w_rb_val + w_rc_val;
            OP_SUB:          w_alu = w_rb_val - w_rc_val;
            OP_AND:          w_alu = w_rb_val & w_rc_val;
            OP_OR:           w_alu = w_rb_val | w_rc_val;
            OP_XOR:          w_alu = w_rb_val ^ w_rc_val;
            OP_NOT:          w_alu = ~w_rb_val;
            OP_MOV:          w_alu = w_rb_val;
            // Any set bit above the shift-index range means the whole word shifts out.
            OP_LSL:          w_alu = (|w_rc_val[WORD_SIZE-1:c_SH_W]) ? '0 : (w_rb_val << w_rc_val[c_SH_W-1:0]);
            OP_LSR:          w_alu = (|w_rc_val[WORD_SIZE-1:c_SH_W]) ? '0 : (w_rb_val >> w_rc_val[c_SH_W-1:0]);
            OP_SHORT_TO_REG: w_alu = {{(WORD_SIZE-8){1'b0}}, w_imm8};
            default:         w_alu = '0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ir_nxt    = r_ir;
        w_rf_we     = 1'b0;
        w_rf_wdata  = w_alu;
        case (r_state)
            S_FETCH: begin
                w_ir_nxt    = w_ram_rdata;
                w_pc_nxt    = r_pc + 1'b1;
                w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                w_state_nxt = S_FETCH;
                case (w_opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT,
                    OP_LSL, OP_LSR, OP_MOV, OP_SHORT_TO_REG: w_rf_we = 1'b1;
                    OP_JMP:            w_pc_nxt = w_imm8;
                    OP_BEQZ:           if (w_ra_val == '0) w_pc_nxt = w_imm8;
                    OP_LOAD, OP_STORE: w_state_nxt = S_MEM;
                    OP_HALT:           w_state_nxt = c_HALT_STATE;
                    OP_NOP:            w_state_nxt = S_FETCH;
                    default:           w_state_nxt = S_FETCH;
                endcase
            end
            S_MEM: begin
                w_state_nxt = S_FETCH;
                if (w_opcode == OP_LOAD) begin
                    w_rf_we    = 1'b1;
                    w_rf_wdata = w_ram_rdata;
                end
            end
            S_HALTED: w_state_nxt = S_HALTED;
            default:  w_state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
            r_pc    <= '0;
            r_ir    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_ir    <= w_ir_nxt;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mcpu_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mcpu_core : scoreboard bench for mcpu_core (register and RAM writes)  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_mcpu_core;
    localparam int OP_ADD = 1, OP_SUB = 2, OP_AND = 3, OP_OR = 4, OP_XOR = 5;
    localparam int OP_NOT = 6, OP_LSL = 7, OP_LSR = 8, OP_SHORT = 9, OP_LOAD = 10;
    localparam int OP_STORE = 11, OP_JMP = 12, OP_BEQZ = 13, OP_MOV = 14, OP_HALT = 15;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mcpu_core dut (
        .clk   (clk),
        .reset (reset)
    );

    mcpu_core_if #(.AW(8), .DW(16)) mon_if ();
    assign mon_if.addr  = dut.w_ram_addr;
    assign mon_if.wdata = dut.w_ram_wdata;
    assign mon_if.we    = dut.w_ram_we;
    assign mon_if.rdata = dut.w_ram_rdata;

    typedef struct packed {
        logic        is_mem;
        logic [7:0]  idx;
        logic [15:0] val;
    } ev_t;

    ev_t sb[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic observe(input string tag, input ev_t got);
        ev_t exp;
        if (sb.size() == 0) begin
            check({tag, "_unexpected"}, 32'(sb.size()), 32'd1);
        end else begin
            exp = sb.pop_front();
            check(tag, 32'(got), 32'(exp));
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (dut.w_rf_we)  observe("reg_wr", {1'b0, 4'h0, dut.w_ra_idx, dut.w_rf_wdata});
            if (mon_if.we)    observe("ram_wr", {1'b1, mon_if.addr, mon_if.wdata});
        end
    end

    function automatic logic [15:0] ins(input int op, input int a, input int b, input int c);
        return {op[3:0], a[3:0], b[3:0], c[3:0]};
    endfunction

    function automatic logic [15:0] insi(input int op, input int a, input int imm);
        return {op[3:0], a[3:0], imm[7:0]};
    endfunction

    task automatic exp_reg(input int idx, input logic [15:0] val);
        sb.push_back({1'b0, 8'(idx), val});
    endtask

    task automatic exp_mem(input int addr, input logic [15:0] val);
        sb.push_back({1'b1, 8'(addr), val});
    endtask

    task automatic hold_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 256; i++) dut.raminst.mem[i] <= 16'h0000;
        #1;
    endtask

    task automatic set_mem(input int a, input logic [15:0] v);
        dut.raminst.mem[a] <= v;
    endtask

    task automatic set_reg(input int r, input logic [15:0] v);
        dut.regfileinst.R[r] <= v;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);

        // Constant build-up and aliased shift
        hold_reset();
        set_mem(0, insi(OP_SHORT, 0, 8'h13));
        set_mem(1, insi(OP_SHORT, 1, 8'hEE));
        set_mem(2, insi(OP_SHORT, 3, 8'h08));
        set_mem(3, ins(OP_LSL, 0, 0, 3));
        set_mem(4, ins(OP_ADD, 2, 1, 0));
        set_mem(5, insi(OP_SHORT, 4, 8'h13));
        set_mem(6, insi(OP_SHORT, 5, 8'hFC));
        set_mem(7, insi(OP_SHORT, 6, 8'h08));
        set_mem(8, ins(OP_LSL, 4, 4, 6));
        set_mem(9, ins(OP_ADD, 7, 4, 5));
        set_mem(10, insi(OP_JMP, 0, 10));
        #1;
        check("rst_pc", dut.r_pc, 0);
        check("rst_ir", dut.r_ir, 0);
        check("rst_state", 32'(dut.r_state), 0);
        exp_reg(0, 16'h0013); exp_reg(1, 16'h00EE); exp_reg(3, 16'h0008);
        exp_reg(0, 16'h1300); exp_reg(2, 16'h13EE);
        exp_reg(4, 16'h0013); exp_reg(5, 16'h00FC); exp_reg(6, 16'h0008);
        exp_reg(4, 16'h1300); exp_reg(7, 16'h13FC);
        release_reset();
        cycles(10);
        check("p1_r0", dut.regfileinst.R[0], 16'h1300);
        check("p1_r1", dut.regfileinst.R[1], 16'h00EE);
        check("p1_r2", dut.regfileinst.R[2], 16'h13EE);
        cycles(10);
        check("p2_r4", dut.regfileinst.R[4], 16'h1300);
        check("p2_r7", dut.regfileinst.R[7], 16'h13FC);
        check("p2_r2", dut.regfileinst.R[2], 16'h13EE);
        cycles(4);
        check("p1_sb_empty", 32'(sb.size()), 0);

        // ALU, shift boundaries and SUB wrap
        hold_reset();
        set_reg(0, 16'hAAAA); set_reg(1, 16'h8001); set_reg(2, 16'd16);
        set_reg(3, 16'h5555); set_reg(13, 16'hF0F0); set_reg(14, 16'h3C3C);
        set_reg(15, 16'h0100);
        set_mem(0, ins(OP_LSL, 3, 1, 2));
        set_mem(1, insi(OP_SHORT, 2, 1));
        set_mem(2, ins(OP_LSR, 4, 1, 2));
        set_mem(3, insi(OP_SHORT, 10, 0));
        set_mem(4, insi(OP_SHORT, 11, 1));
        set_mem(5, ins(OP_SUB, 12, 10, 11));
        set_mem(6, ins(OP_AND, 5, 13, 14));
        set_mem(7, ins(OP_OR, 6, 13, 14));
        set_mem(8, ins(OP_XOR, 7, 13, 14));
        set_mem(9, ins(OP_NOT, 8, 13, 0));
        set_mem(10, ins(OP_MOV, 9, 14, 0));
        set_mem(11, ins(OP_LSL, 0, 1, 15));
        set_mem(12, insi(OP_JMP, 0, 12));
        exp_reg(3, 16'h0000); exp_reg(2, 16'h0001); exp_reg(4, 16'h4000);
        exp_reg(10, 16'h0000); exp_reg(11, 16'h0001); exp_reg(12, 16'hFFFF);
        exp_reg(5, 16'h3030); exp_reg(6, 16'hFCFC); exp_reg(7, 16'hCCCC);
        exp_reg(8, 16'h0F0F); exp_reg(9, 16'h3C3C); exp_reg(0, 16'h0000);
        release_reset();
        cycles(28);
        check("alu_r3", dut.regfileinst.R[3], 16'h0000);
        check("alu_r4", dut.regfileinst.R[4], 16'h4000);
        check("alu_r12", dut.regfileinst.R[12], 16'hFFFF);
        check("alu_sb_empty", 32'(sb.size()), 0);

        // STORE then LOAD through an address whose upper byte is ignored
        hold_reset();
        set_reg(5, 16'hBEEF); set_reg(6, 16'h1280); set_reg(7, 16'h0000);
        set_mem(0, ins(OP_STORE, 5, 6, 0));
        set_mem(1, ins(OP_LOAD, 7, 6, 0));
        set_mem(2, insi(OP_JMP, 0, 2));
        exp_mem(8'h80, 16'hBEEF);
        exp_reg(7, 16'hBEEF);
        release_reset();
        cycles(3);
        check("st_pc", dut.r_pc, 1);
        check("st_state", 32'(dut.r_state), 0);
        cycles(2);
        check("ld_state_mem", 32'(dut.r_state), 2);
        check("ld_r7_pending", dut.regfileinst.R[7], 16'h0000);
        check("ld_bus_addr", mon_if.addr, 8'h80);
        check("ld_bus_rdata", mon_if.rdata, 16'hBEEF);
        cycles(1);
        check("ld_r7", dut.regfileinst.R[7], 16'hBEEF);
        check("st_mem80", dut.raminst.mem[8'h80], 16'hBEEF);
        cycles(4);
        check("mem_sb_empty", 32'(sb.size()), 0);

        // Taken and untaken BEQZ, JMP loop
        hold_reset();
        set_reg(1, 16'h0000); set_reg(8, 16'h0000); set_reg(9, 16'h0005);
        set_mem(0, insi(OP_BEQZ, 8, 8'h20));
        set_mem(1, insi(OP_SHORT, 1, 8'hAA));
        set_mem(8'h20, insi(OP_SHORT, 1, 8'h55));
        set_mem(8'h21, insi(OP_BEQZ, 9, 8'h30));
        set_mem(8'h30, insi(OP_SHORT, 1, 8'h99));
        set_mem(8'h22, insi(OP_JMP, 0, 8'h05));
        set_mem(6, insi(OP_JMP, 0, 8'h05));
        exp_reg(1, 16'h0055);
        release_reset();
        cycles(2);
        check("beqz_taken_pc", dut.r_pc, 8'h20);
        cycles(2);
        check("beqz_target_r1", dut.regfileinst.R[1], 16'h0055);
        cycles(2);
        check("beqz_fall_pc", dut.r_pc, 8'h22);
        cycles(2);
        check("jmp_pc", dut.r_pc, 8'h05);
        cycles(2);
        check("nop_pc", dut.r_pc, 8'h06);
        cycles(2);
        check("loop_pc_a", dut.r_pc, 8'h05);
        cycles(4);
        check("loop_pc_b", dut.r_pc, 8'h05);
        check("br_sb_empty", 32'(sb.size()), 0);

        // PC wrap 255 -> 0
        hold_reset();
        set_reg(1, 16'h0000);
        set_mem(0, insi(OP_JMP, 0, 8'hFF));
        set_mem(255, insi(OP_SHORT, 1, 8'h42));
        exp_reg(1, 16'h0042); exp_reg(1, 16'h0042);
        release_reset();
        cycles(3);
        check("wrap_pc", dut.r_pc, 0);
        cycles(1);
        check("wrap_r1", dut.regfileinst.R[1], 16'h0042);
        cycles(4);
        check("wrap_sb_empty", 32'(sb.size()), 0);

        // Reset asserted during EXEC of an ADD
        hold_reset();
        set_reg(3, 16'h0BAD); set_reg(4, 16'h1111); set_reg(5, 16'h2222);
        set_mem(0, ins(OP_ADD, 3, 4, 5));
        set_mem(1, insi(OP_JMP, 0, 1));
        release_reset();
        cycles(1);
        check("abort_in_exec", 32'(dut.r_state), 1);
        reset = 1'b0;
        #1;
        check("abort_pc", dut.r_pc, 0);
        check("abort_ir", dut.r_ir, 0);
        check("abort_state", 32'(dut.r_state), 0);
        cycles(3);
        check("abort_r3", dut.regfileinst.R[3], 16'h0BAD);
        exp_reg(3, 16'h3333);
        release_reset();
        cycles(2);
        check("rerun_r3", dut.regfileinst.R[3], 16'h3333);
        cycles(2);
        check("abort_sb_empty", 32'(sb.size()), 0);

        // Opcode 15
        hold_reset();
        set_reg(1, 16'h0000);
        set_mem(0, insi(OP_SHORT, 1, 1));
        set_mem(1, insi(OP_HALT, 0, 0));
        set_mem(2, insi(OP_SHORT, 1, 2));
        set_mem(3, insi(OP_JMP, 0, 3));
`ifdef MCPU_HALT_EN
        exp_reg(1, 16'h0001);
        release_reset();
        cycles(4);
        check("halt_state", 32'(dut.r_state), 3);
        check("halt_pc", dut.r_pc, 2);
        cycles(20);
        check("halt_pc_stable", dut.r_pc, 2);
        check("halt_r1", dut.regfileinst.R[1], 16'h0001);
`else
        exp_reg(1, 16'h0001); exp_reg(1, 16'h0002);
        release_reset();
        cycles(8);
        check("op15_nop_pc", dut.r_pc, 3);
        check("op15_nop_r1", dut.regfileinst.R[1], 16'h0002);
`endif
        check("op15_sb_empty", 32'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
